// File: rtl/oc8051_su_gate_pkg.sv
// Shared constants for the supervisor-entry gate: default gate geometry, fault codes, gate decode helper.
// Fault-code width follows OC8051_SU_GATE_ALIGN_CHK_EN (3 bits when defined, 2 otherwise).
package oc8051_su_gate_pkg;

  localparam logic [15:0] OC8051_SUG_GATE_BASE        = 16'hF000;
  localparam int          OC8051_SUG_GATE_COUNT       = 16;
  localparam int          OC8051_SUG_GATE_STRIDE_LOG2 = 3;
  localparam int          OC8051_SUG_DEPTH            = 32;

`ifdef OC8051_SU_GATE_ALIGN_CHK_EN
  localparam int FAULT_W = 3;
`else
  localparam int FAULT_W = 2;
`endif

  typedef logic [FAULT_W-1:0] fault_code_t;

  localparam fault_code_t OC8051_SUG_F_NONE  = FAULT_W'(0);
  localparam fault_code_t OC8051_SUG_F_OVF   = FAULT_W'(1);
  localparam fault_code_t OC8051_SUG_F_UNF   = FAULT_W'(2);
  localparam fault_code_t OC8051_SUG_F_BOTH  = FAULT_W'(3);
`ifdef OC8051_SU_GATE_ALIGN_CHK_EN
  localparam fault_code_t OC8051_SUG_F_ALIGN = FAULT_W'(4);
`endif

  // Returns {in_region, aligned}; region end is formed at 17 bits so a region touching 16'hFFFF cannot wrap.
  function automatic logic [1:0] sug_decode(input logic [15:0] target, input logic [15:0] base,
                                            input int count, input int stride_log2);
    logic [16:0] region_end;
    logic [15:0] mask;
    region_end = {1'b0, base} + (17'(count) << stride_log2);
    mask       = 16'((17'd1 << stride_log2) - 17'd1);
    return {(({1'b0, target} >= {1'b0, base}) && ({1'b0, target} < region_end)),
            ((target & mask) == 16'd0)};
  endfunction

endpackage

// File: rtl/oc8051_su_bitstack.sv
// One-bit-per-frame LIFO recording whether each open call frame entered supervisor mode.
module oc8051_su_bitstack
  import oc8051_su_gate_pkg::*;
#(
  parameter int DEPTH = OC8051_SUG_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       push_bit,
  output logic       top_bit,
  output logic [6:0] level,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [(1<<AW)-1:0] bits_r;
  logic [AW-1:0]      top_idx;

  assign full    = (level == 7'(DEPTH));
  assign empty   = (level == 7'd0);
  assign top_idx = level[AW-1:0] - AW'(1);
  assign top_bit = empty ? 1'b0 : bits_r[top_idx];

  // Stack storage and fill level; push wins only when not full, pop only when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_r <= '0;
      level  <= 7'd0;
    end else if (push && !full) begin
      bits_r[level[AW-1:0]] <= push_bit;
      level                 <= level + 7'd1;
    end else if (pop && !empty) begin
      level <= level - 7'd1;
    end
  end

endmodule

// File: rtl/oc8051_su_gate.sv
// Privilege-entry gate: turns retired gate calls/returns into enter/leave pulses and tracks sticky faults.
// Build option OC8051_SU_GATE_ALIGN_CHK_EN flags in-region misaligned calls as fault code 4.
module oc8051_su_gate
  import oc8051_su_gate_pkg::*;
#(
  parameter logic [15:0] GATE_BASE        = OC8051_SUG_GATE_BASE,
  parameter int          GATE_COUNT       = OC8051_SUG_GATE_COUNT,
  parameter int          GATE_STRIDE_LOG2 = OC8051_SUG_GATE_STRIDE_LOG2,
  parameter int          DEPTH            = OC8051_SUG_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic               is_call,
  input  logic               is_ret,
  input  logic [15:0]        call_target,
  output logic               enter_su_mode,
  output logic               leave_su_mode,
  output logic [6:0]         su_depth,
  output logic [6:0]         stack_level,
  output logic               gate_fault,
  output logic [FAULT_W-1:0] fault_code
);

  logic        in_region, aligned, gate_hit;
  logic        call_ev, ret_ev, both_ev;
  logic        push, pop, full, empty, top_bit;
  fault_code_t new_fault;

  assign {in_region, aligned} = sug_decode(call_target, GATE_BASE, GATE_COUNT, GATE_STRIDE_LOG2);
  assign gate_hit = in_region & aligned;

  assign call_ev = instr_valid & is_call & ~is_ret;
  assign ret_ev  = instr_valid & is_ret & ~is_call;
  assign both_ev = instr_valid & is_call & is_ret;
  assign push    = call_ev & ~full;
  assign pop     = ret_ev & ~empty;

  oc8051_su_bitstack #(.DEPTH(DEPTH)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .push_bit(gate_hit),
    .top_bit (top_bit),
    .level   (stack_level),
    .full    (full),
    .empty   (empty)
  );

  // Classify this cycle's fault cause, if any.
  always_comb begin
    new_fault = OC8051_SUG_F_NONE;
    if (call_ev && full) begin
      new_fault = OC8051_SUG_F_OVF;
    end else if (ret_ev && empty) begin
      new_fault = OC8051_SUG_F_UNF;
    end else if (both_ev) begin
      new_fault = OC8051_SUG_F_BOTH;
`ifdef OC8051_SU_GATE_ALIGN_CHK_EN
    end else if (push && in_region && !aligned) begin
      new_fault = OC8051_SUG_F_ALIGN;
`endif
    end else begin
      new_fault = OC8051_SUG_F_NONE;
    end
  end

  // Registered privilege pulses, gate-frame depth and sticky first-fault capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_su_mode <= 1'b0;
      leave_su_mode <= 1'b0;
      su_depth      <= 7'd0;
      gate_fault    <= 1'b0;
      fault_code    <= OC8051_SUG_F_NONE;
    end else begin
      enter_su_mode <= push & gate_hit;
      leave_su_mode <= pop & top_bit;
      if (push && gate_hit) begin
        su_depth <= su_depth + 7'd1;
      end else if (pop && top_bit) begin
        su_depth <= su_depth - 7'd1;
      end
      if (new_fault != OC8051_SUG_F_NONE) begin
        gate_fault <= 1'b1;
        if (!gate_fault) begin
          fault_code <= new_fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_oc8051_su_gate.sv
// Scoreboard bench for oc8051_su_gate: a behavioural model queues expectations, a monitor compares each cycle.
module tb_oc8051_su_gate;

  localparam int DEPTH = 32;
`ifdef OC8051_SU_GATE_ALIGN_CHK_EN
  localparam int FCW = 3;
`else
  localparam int FCW = 2;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           instr_valid = 1'b0;
  logic           is_call = 1'b0;
  logic           is_ret = 1'b0;
  logic [15:0]    call_target = 16'h0000;
  logic           enter_su_mode, leave_su_mode, gate_fault;
  logic [6:0]     su_depth, stack_level;
  logic [FCW-1:0] fault_code;

  always #5 clk = ~clk;

  oc8051_su_gate dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .is_call      (is_call),
    .is_ret       (is_ret),
    .call_target  (call_target),
    .enter_su_mode(enter_su_mode),
    .leave_su_mode(leave_su_mode),
    .su_depth     (su_depth),
    .stack_level  (stack_level),
    .gate_fault   (gate_fault),
    .fault_code   (fault_code)
  );

  typedef struct packed {
    logic       enter;
    logic       leave;
    logic [6:0] su;
    logic [6:0] lvl;
    logic       flt;
    logic [2:0] code;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         enter_cnt = 0;
  int         leave_cnt = 0;
  bit         m_stack[$];
  int         m_su = 0;
  bit         m_flt = 1'b0;
  logic [2:0] m_code = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, compared just after the capturing edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("enter_su_mode", 32'(enter_su_mode), 32'(e.enter));
      check("leave_su_mode", 32'(leave_su_mode), 32'(e.leave));
      check("su_depth", 32'(su_depth), 32'(e.su));
      check("stack_level", 32'(stack_level), 32'(e.lvl));
      check("gate_fault", 32'(gate_fault), 32'(e.flt));
      check("fault_code", 32'(fault_code), 32'(e.code));
      check("enter_leave_excl", 32'(enter_su_mode & leave_su_mode), 32'd0);
      enter_cnt += int'(enter_su_mode);
      leave_cnt += int'(leave_su_mode);
    end
  end

  function automatic void mfault(input logic [2:0] code);
    if (!m_flt) m_code = code;
    m_flt = 1'b1;
  endfunction

  // Drive one instruction slot and queue its expected registered response.
  task automatic step(input bit v, input bit c, input bit r, input logic [15:0] t);
    bit in_reg, al, hit, b, e_en, e_lv;
    @(negedge clk);
    instr_valid = v; is_call = c; is_ret = r; call_target = t;
    in_reg = (t >= 16'hF000) && (t < 16'hF080);
    al     = (t[2:0] == 3'b000);
    hit    = in_reg && al;
    e_en = 1'b0; e_lv = 1'b0;
    if (v && c && r) begin
      mfault(3'd3);
    end else if (v && c) begin
      if (m_stack.size() == DEPTH) mfault(3'd1);
      else begin
        m_stack.push_back(hit);
        if (hit) begin e_en = 1'b1; m_su++; end
`ifdef OC8051_SU_GATE_ALIGN_CHK_EN
        if (in_reg && !al) mfault(3'd4);
`endif
      end
    end else if (v && r) begin
      if (m_stack.size() == 0) mfault(3'd2);
      else begin
        b = m_stack.pop_back();
        if (b) begin e_lv = 1'b1; m_su--; end
      end
    end
    sb.push_back('{e_en, e_lv, 7'(m_su), 7'(m_stack.size()), m_flt, m_code});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_enter"}, 32'(enter_su_mode), 32'd0);
    check({tag, "_leave"}, 32'(leave_su_mode), 32'd0);
    check({tag, "_su_depth"}, 32'(su_depth), 32'd0);
    check({tag, "_stack_level"}, 32'(stack_level), 32'd0);
    check({tag, "_gate_fault"}, 32'(gate_fault), 32'd0);
    check({tag, "_fault_code"}, 32'(fault_code), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    drain();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst");
    m_stack.delete(); m_su = 0; m_flt = 1'b0; m_code = 3'd0;
    @(negedge clk);
    instr_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0; call_target = 16'h0000;
    rst = 1'b0;
  endtask

  initial begin
    int e0, l0;
    #12;
    check_zero("por");
    @(negedge clk);
    rst = 1'b0;

    // Single gate call and matching return.
    step(1'b1, 1'b1, 1'b0, 16'hF008);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle();

    // Ordinary call, gate call, three returns (last underflows).
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'h1234);
    step(1'b1, 1'b1, 1'b0, 16'hF000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle();

    // Fill to DEPTH, one overflow call, then unwind.
    do_reset();
    drain();
    e0 = enter_cnt; l0 = leave_cnt;
    for (int i = 0; i <= DEPTH; i++) step(1'b1, 1'b1, 1'b0, 16'hF000 + 16'((i % 16) << 3));
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle();
    drain();
    check("depth_enter_pulses", 32'(enter_cnt - e0), 32'd32);
    check("depth_leave_pulses", 32'(leave_cnt - l0), 32'd32);

    // Simultaneous call+ret, unqualified strobes, later underflow keeps first code.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'hF010);
    step(1'b1, 1'b1, 1'b1, 16'hF000);
    step(1'b0, 1'b1, 1'b0, 16'hF000);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle();

    // Region boundaries and alignment.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'hF004);
    step(1'b1, 1'b1, 1'b0, 16'hF080);
    step(1'b1, 1'b1, 1'b0, 16'hEFF8);
    step(1'b1, 1'b1, 1'b0, 16'hF078);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
    idle();

    // Reset while three gate frames are open, then a fresh gate call.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'hF020);
    idle();
    do_reset();
    step(1'b1, 1'b1, 1'b0, 16'hF000);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
